counter_4bit: RTL and testbench

- Free-running binary up-counter with asynchronous active-low reset.
- Leaf block; provides a cycle count, e.g. for bring-up, simulation smoke tests and waveform sanity checks.
- No enable, no load, no terminal-count output. It counts on every clock while out of reset.

---
 rtl/counter_4bit.sv | 24 ++
 tb/tb_counter_4bit.sv | 109 ++++++++++
 2 files changed

// File: rtl/counter_4bit.sv
// Free-running unsigned up-counter with asynchronous active-low clear.
// Wraps modulo 2^WIDTH; positional port order (cnt, clk, rst) is relied on by existing instances.
module counter_4bit #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] cnt,
    input  logic             clk,
    input  logic             rst
);

    // Carry out of the MSB is dropped, giving the 2^WIDTH-1 -> 0 wrap.
    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
        return WIDTH'(v + 1'b1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= wrap_inc(cnt);
        end
    end

endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit: directed reset/wrap/clear steps, then randomized
// reset activity compared against an "edges since release, modulo 2^WIDTH" reference.
module tb_counter_4bit;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cnt;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    counter_4bit #(.WIDTH(W)) dut (
        .cnt (cnt),
        .clk (clk),
        .rst (rst)
    );

    // Rising edges at 5, 15, 25 ... ns
    always #5 clk = ~clk;

    // Reference: the count equals the number of counted edges since release, reduced mod 2^W.
    function automatic logic [W-1:0] model(input int n);
        return W'(n % MOD);
    endfunction

    task automatic check(input logic [W-1:0] obs, input logic [W-1:0] exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        bit r;

        // Held in reset from time zero; the edges at 5 and 15 ns must be ignored.
        rst = 1'b0;
        #1  check(cnt, '0, "reset_t1");
        #9  check(cnt, '0, "reset_t10");
        #10 check(cnt, '0, "reset_t20");

        // Release at 20 ns; count through one wrap and on to 4 by the 215 ns edge.
        rst   = 1'b1;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            edges++;
            check(cnt, model(edges), "count");
            if (edges == 16) check(cnt, '0, "wrap_15_to_0");
        end
        check(cnt, 4'd4, "after_20_edges");

        // Asynchronous clear at 220 ns, between edges.
        #4 rst = 1'b0;
        #1 check(cnt, '0, "async_clear");
        repeat (2) begin
            @(posedge clk);
            #1 check(cnt, '0, "held_in_reset");
        end

        // Release between edges: restarts from 0, first edge gives 1.
        #4 rst = 1'b1;
        edges = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            edges++;
            check(cnt, model(edges), "re_release");
        end

        // Release coincident with a rising edge: reset wins on that edge.
        @(negedge clk);
        rst = 1'b0;
        #1 check(cnt, '0, "coinc_pre_clear");
        @(posedge clk);
        rst <= 1'b1;
        #1 check(cnt, '0, "coinc_edge");
        @(posedge clk);
        #1 check(cnt, 4'd1, "coinc_next_edge");
        edges = 1;

        // Randomized run with occasional mid-count resets.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            r   = ($urandom_range(0, 11) != 0);
            rst = r;
            if (!r) begin
                #1 check(cnt, '0, "rand_async_clear");
            end
            @(posedge clk);
            #1;
            if (r) edges++;
            else   edges = 0;
            check(cnt, model(edges), "rand_count");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
